x_phaser_ref_lockmon: RTL and testbench
=======================================

X_PHASER_REF_LOCKMON -- requirements
Module: x_phaser_ref_lockmon

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent monitored reference channels (1..16).
REQ-002 Parameter CNT_W, default 12: width of the period counter and period values, in CLK cycles.
REQ-003 Parameter PERIOD_MIN, default 8: minimum legal period in CLK cycles.
REQ-004 Parameter PERIOD_MAX, default 64: maximum legal period in CLK cycles (PERIOD_MAX + JITTER_TOL < 2^CNT_W).
REQ-005 Parameter JITTER_TOL, default 1: maximum allowed |period - previous period| in CLK cycles.
REQ-006 Parameter LOCK_CNT, default 6: consecutive good periods required to assert lock.
REQ-007 Parameter UNLOCK_CNT, default 2: consecutive bad periods while locked required to drop lock.
REQ-008 Port CLK, input, 1: single clock; all logic rising-edge.
REQ-009 Port RST, input, 1: asynchronous, active-high reset.
REQ-010 Port REF_TICK, input, CHANNELS: per-channel single-cycle pulse marking one reference edge, already synchronous to CLK.
REQ-011 Port PWRDWN, input, CHANNELS: per-channel synchronous power-down, active high.
REQ-012 Port ERR_CLR, input, 1: synchronous pulse clearing all RANGE_ERR bits.
REQ-013 Port LOCKED, output, CHANNELS: per-channel lock indication, registered.
REQ-014 Port LOCKED_ALL, output, 1: all powered-up channels locked, registered.
REQ-015 Port PERIOD, output, CHANNELS*CNT_W: last measured period per channel, channel n at bits [n*CNT_W +: CNT_W].
REQ-016 Port RANGE_ERR, output, CHANNELS: sticky flag, period outside [PERIOD_MIN, PERIOD_MAX] detected.

Function
REQ-017 Each channel SHALL measure period P as the number of CLK cycles between successive REF_TICK pulses (ticks at cycles 0 and 10 give P=10).
REQ-018 The first tick after reset, power-down release or timeout SHALL start measurement only; no period is evaluated and PERIOD is unchanged.
REQ-019 A period SHALL be good when PERIOD_MIN <= P <= PERIOD_MAX and, if a previous period is valid, |P - previous| <= JITTER_TOL; otherwise it is bad.
REQ-020 The first evaluated period after a restart has no previous; it SHALL be judged on range only.
REQ-021 Timeout: with no tick for PERIOD_MAX+JITTER_TOL+1 cycles, the channel SHALL evaluate one bad period, invalidate the previous period and wait for a new first tick; the counter SHALL never wrap.
REQ-022 PERIOD SHALL update on every evaluated tick, one cycle after the tick; timeouts do not update PERIOD.
REQ-023 Per-channel states: IDLE (wait first tick), ACQ (counting good periods), LOCK.
REQ-024 IDLE -> ACQ on first tick; good count cleared.
REQ-025 ACQ: good period increments good count; bad period clears it; good count reaching LOCK_CNT SHALL enter LOCK with LOCKED high in the cycle after the evaluating tick.
REQ-026 LOCK: bad period increments bad count, good period clears it; bad count reaching UNLOCK_CNT SHALL enter ACQ with LOCKED low the next cycle and good count cleared; fewer than UNLOCK_CNT consecutive bad periods SHALL NOT drop LOCKED.
REQ-027 A timeout SHALL send the channel to IDLE after being counted (in LOCK it counts toward UNLOCK_CNT; if the threshold is not reached, LOCKED stays high until the next restart sequence fails).
REQ-028 PWRDWN[n] high SHALL force IDLE, LOCKED[n]=0, all counters and previous-period validity cleared; PWRDWN overrides a same-cycle tick.
REQ-029 RANGE_ERR[n] SHALL set one cycle after any evaluated period out of range; ERR_CLR clears all bits; set wins over a same-cycle clear.
REQ-030 LOCKED_ALL SHALL be 1 when every channel with PWRDWN=0 has LOCKED=1, and 0 when all channels are powered down.
REQ-031 Channels SHALL be fully independent; events on one SHALL NOT affect another.

Reset
REQ-032 RST high SHALL immediately force LOCKED=0, LOCKED_ALL=0, PERIOD=0, RANGE_ERR=0, all channels IDLE, all counters 0.
REQ-033 Reset assertion mid-acquisition or in LOCK SHALL discard all history; after release the first tick is a start tick per REQ-018.

Verification
REQ-034 Ch0 ticks every 20 cycles -> PERIOD[0]=20 after 2nd tick; LOCKED[0] rises one cycle after 7th tick; other channels stay 0.
REQ-035 Ch0 locked at 20, then periods 22, 20 -> no unlock (one bad period); then 22, 24 -> LOCKED[0] falls after the 24-period tick.
REQ-036 Ch1 ticks every 100 cycles -> RANGE_ERR[1]=1 after 2nd tick, never locks; ERR_CLR pulse same cycle as next bad tick -> RANGE_ERR[1] stays 1.
REQ-037 Ch2 locked at 30, ticks stop -> bad period counted at 66 cycles silence, IDLE; resuming ticks at 30 -> relock after 1+6 ticks.
REQ-038 All channels locked, PWRDWN[3]=1 -> LOCKED[3]=0 next cycle, LOCKED_ALL stays 1; all PWRDWN=1 -> LOCKED_ALL=0.
REQ-039 RST asserted asynchronously mid-LOCK between clock edges -> all outputs 0 without waiting for a CLK edge; relock requires a full sequence.

Source files
------------

// File: rtl/x_phaser_ref_lockmon.sv
// Per-channel reference clock lock monitor: measures tick-to-tick periods in CLK cycles,
// qualifies them against range and jitter limits, and tracks acquisition/lock per channel.
module x_phaser_ref_lockmon #(
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned CNT_W      = 12,
  parameter int unsigned PERIOD_MIN = 8,
  parameter int unsigned PERIOD_MAX = 64,
  parameter int unsigned JITTER_TOL = 1,
  parameter int unsigned LOCK_CNT   = 6,
  parameter int unsigned UNLOCK_CNT = 2
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [CHANNELS-1:0]       REF_TICK,
  input  logic [CHANNELS-1:0]       PWRDWN,
  input  logic                      ERR_CLR,
  output logic [CHANNELS-1:0]       LOCKED,
  output logic                      LOCKED_ALL,
  output logic [CHANNELS*CNT_W-1:0] PERIOD,
  output logic [CHANNELS-1:0]       RANGE_ERR
);

  // One spare counter bit so the timeout value always fits without wrapping.
  localparam int unsigned CW = CNT_W + 1;
  localparam int unsigned GW = $clog2(LOCK_CNT + 1);
  localparam int unsigned BW = $clog2(UNLOCK_CNT + 1);

  localparam logic [CW-1:0] TMO_C      = CW'(PERIOD_MAX + JITTER_TOL + 1);
  localparam logic [CW-1:0] MIN_C      = CW'(PERIOD_MIN);
  localparam logic [CW-1:0] MAX_C      = CW'(PERIOD_MAX);
  localparam logic [CW-1:0] TOL_C      = CW'(JITTER_TOL);
  localparam logic [GW-1:0] LOCK_C     = GW'(LOCK_CNT);
  localparam logic [BW-1:0] UNLOCK_C   = BW'(UNLOCK_CNT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACQ  = 2'd1,
    ST_LOCK = 2'd2
  } state_e;

  logic [CHANNELS-1:0] locked_d;
  logic                locked_all_q;

  for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   prev_q;
    logic            prev_vld_q;
    logic [GW-1:0]   good_cnt_q;
    logic [BW-1:0]   bad_cnt_q;
    logic [CNT_W-1:0] period_q;
    logic            locked_q;
    logic            err_q;

    logic          active;
    logic          tick;
    logic          eval;
    logic          tmo;
    logic          in_range;
    logic [CW-1:0] diff;
    logic          jit_ok;
    logic          good;
    logic          bad;
    logic          rng_bad;
    logic          lock_hit;
    logic          unlock_hit;

    // Event decode for the current cycle; power-down masks both ticks and timeouts.
    always_comb begin
      active     = (state_q != ST_IDLE);
      tick       = REF_TICK[n] && !PWRDWN[n];
      eval       = tick && active;
      tmo        = active && !tick && !PWRDWN[n] && (cnt_q == TMO_C);
      in_range   = (cnt_q >= MIN_C) && (cnt_q <= MAX_C);
      diff       = (cnt_q >= prev_q) ? (cnt_q - prev_q) : (prev_q - cnt_q);
      jit_ok     = !prev_vld_q || (diff <= TOL_C);
      good       = eval && in_range && jit_ok;
      bad        = (eval && !good) || tmo;
      rng_bad    = (eval && !in_range) || tmo;
      lock_hit   = good && (state_q == ST_ACQ) && ((good_cnt_q + GW'(1)) >= LOCK_C);
      unlock_hit = bad && locked_q && ((bad_cnt_q + BW'(1)) >= UNLOCK_C);
    end

    assign locked_d[n] = PWRDWN[n] ? 1'b0 :
                         lock_hit  ? 1'b1 :
                         unlock_hit ? 1'b0 : locked_q;

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        state_q    <= ST_IDLE;
        cnt_q      <= '0;
        prev_q     <= '0;
        prev_vld_q <= 1'b0;
        good_cnt_q <= '0;
        bad_cnt_q  <= '0;
        period_q   <= '0;
        locked_q   <= 1'b0;
        err_q      <= 1'b0;
      end else begin
        locked_q <= locked_d[n];
        err_q    <= (err_q && !ERR_CLR) || rng_bad;
        if (PWRDWN[n]) begin
          state_q    <= ST_IDLE;
          cnt_q      <= '0;
          prev_vld_q <= 1'b0;
          good_cnt_q <= '0;
          bad_cnt_q  <= '0;
        end else begin
          case (state_q)
            ST_IDLE: begin
              if (tick) begin
                state_q    <= ST_ACQ;
                cnt_q      <= CW'(1);
                good_cnt_q <= '0;
                prev_vld_q <= 1'b0;
              end
            end
            default: begin
              if (eval) begin
                cnt_q    <= CW'(1);
                period_q <= cnt_q[CNT_W-1:0];
              end else if (tmo) begin
                cnt_q      <= '0;
                state_q    <= ST_IDLE;
                prev_vld_q <= 1'b0;
              end else begin
                cnt_q <= cnt_q + CW'(1);
              end

              if (good) begin
                bad_cnt_q  <= '0;
                prev_q     <= cnt_q;
                prev_vld_q <= 1'b1;
                if (lock_hit) begin
                  state_q    <= ST_LOCK;
                  good_cnt_q <= '0;
                end else if (state_q == ST_ACQ) begin
                  good_cnt_q <= good_cnt_q + GW'(1);
                end
              end else if (bad) begin
                good_cnt_q <= '0;
                if (unlock_hit) begin
                  bad_cnt_q <= '0;
                  if (!tmo) state_q <= ST_ACQ;
                end else if (locked_q) begin
                  bad_cnt_q <= bad_cnt_q + BW'(1);
                end
                // While acquiring, the jitter reference follows the incoming rate so a
                // changed frequency can still be acquired; in lock it holds the last good period.
                if (eval && in_range && (state_q == ST_ACQ)) begin
                  prev_q     <= cnt_q;
                  prev_vld_q <= 1'b1;
                end
              end
            end
          endcase
        end
      end
    end

    assign LOCKED[n]                  = locked_q;
    assign RANGE_ERR[n]               = err_q;
    assign PERIOD[n*CNT_W +: CNT_W]   = period_q;
  end

  // Aggregate lock uses next-state lock so it is aligned with the per-channel outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      locked_all_q <= 1'b0;
    end else begin
      locked_all_q <= (&(locked_d | PWRDWN)) && !(&PWRDWN);
    end
  end

  assign LOCKED_ALL = locked_all_q;

endmodule

// File: tb/tb_x_phaser_ref_lockmon.sv
// Directed scoreboard bench for x_phaser_ref_lockmon: expectations are queued as ticks
// are driven and compared against the DUT after the following clock edge.
module tb_x_phaser_ref_lockmon;

  localparam int CH = 4;
  localparam int CW = 12;

  localparam int K_LVEC = 0;
  localparam int K_LBIT = 1;
  localparam int K_LALL = 2;
  localparam int K_PER  = 3;
  localparam int K_ERR  = 4;

  logic             CLK;
  logic             RST;
  logic [CH-1:0]    REF_TICK;
  logic [CH-1:0]    PWRDWN;
  logic             ERR_CLR;
  logic [CH-1:0]    LOCKED;
  logic             LOCKED_ALL;
  logic [CH*CW-1:0] PERIOD;
  logic [CH-1:0]    RANGE_ERR;

  x_phaser_ref_lockmon #(
    .CHANNELS(CH), .CNT_W(CW), .PERIOD_MIN(8), .PERIOD_MAX(64),
    .JITTER_TOL(1), .LOCK_CNT(6), .UNLOCK_CNT(2)
  ) dut (
    .CLK(CLK), .RST(RST), .REF_TICK(REF_TICK), .PWRDWN(PWRDWN), .ERR_CLR(ERR_CLR),
    .LOCKED(LOCKED), .LOCKED_ALL(LOCKED_ALL), .PERIOD(PERIOD), .RANGE_ERR(RANGE_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string       tag;
    int          kind;
    int          ch;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   per_c[CH];
  int   next_t[CH];
  int   last_t[CH];
  int   ntick[CH];

  function automatic logic [31:0] observe(int kind, int ch);
    case (kind)
      K_LVEC:  return 32'(LOCKED);
      K_LBIT:  return 32'(LOCKED[ch]);
      K_LALL:  return 32'(LOCKED_ALL);
      K_PER:   return 32'(PERIOD[ch*CW +: CW]);
      default: return 32'(RANGE_ERR[ch]);
    endcase
  endfunction

  task automatic push_exp(string tag, int kind, int ch, logic [31:0] v);
    exp_t e;
    e.tag = tag; e.kind = kind; e.ch = ch; e.val = v;
    sb.push_back(e);
  endtask

  task automatic check_all();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.kind, e.ch);
      checks++;
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s: observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic drive();
    logic [CH-1:0] tk;
    tk = '0;
    for (int n = 0; n < CH; n++) begin
      if (next_t[n] >= 0 && cyc >= next_t[n]) begin
        tk[n]     = 1'b1;
        ntick[n]++;
        last_t[n] = cyc;
        next_t[n] = (per_c[n] > 0) ? cyc + per_c[n] : -1;
      end
    end
    REF_TICK = tk;
  endtask

  task automatic clk();
    @(posedge CLK);
    #1;
    cyc++;
    REF_TICK = '0;
    check_all();
  endtask

  task automatic wait_cycles(int n);
    repeat (n) begin
      drive();
      clk();
    end
  endtask

  task automatic start_ch(int ch, int p);
    per_c[ch]  = p;
    next_t[ch] = cyc;
    ntick[ch]  = 0;
  endtask

  task automatic stop_ch(int ch);
    next_t[ch] = -1;
  endtask

  task automatic set_next(int ch, int gap);
    next_t[ch] = last_t[ch] + gap;
  endtask

  // Drives cycles until tick k of channel ch is on the inputs (edge not yet taken).
  task automatic advance_to_tick(int ch, int k);
    for (int b = 0; b < 3000; b++) begin
      drive();
      if (REF_TICK[ch] && ntick[ch] == k) return;
      clk();
    end
    checks++;
    errors++;
    $error("FAIL tick_wait ch%0d: observed no tick %0d, required tick within 3000 cycles", ch, k);
  endtask

  initial begin
    RST = 1'b1; REF_TICK = '0; PWRDWN = '0; ERR_CLR = 1'b0;
    for (int n = 0; n < CH; n++) begin
      per_c[n] = 0; next_t[n] = -1; last_t[n] = 0; ntick[n] = 0;
    end

    // Reset state
    clk(); clk();
    push_exp("rst_locked", K_LVEC, 0, 0);
    push_exp("rst_lall", K_LALL, 0, 0);
    push_exp("rst_per0", K_PER, 0, 0);
    push_exp("rst_err3", K_ERR, 3, 0);
    clk();
    RST = 1'b0;

    // Ch0 at period 20: measure and lock after 7 ticks
    start_ch(0, 20);
    advance_to_tick(0, 1); clk();
    advance_to_tick(0, 2);
    push_exp("per0_before_2nd", K_PER, 0, 0); check_all();
    push_exp("per0_20", K_PER, 0, 20);
    push_exp("lvec_after_2nd", K_LVEC, 0, 0);
    clk();
    advance_to_tick(0, 7);
    push_exp("lvec_pre_lock", K_LVEC, 0, 0); check_all();
    push_exp("lvec_lock0", K_LVEC, 0, 4'b0001);
    push_exp("lall_partial", K_LALL, 0, 0);
    clk();

    // Ch0 jitter: 22,20 keeps lock; 22,24 drops it
    set_next(0, 22);
    advance_to_tick(0, 8);
    push_exp("per0_22", K_PER, 0, 22); push_exp("lock_one_bad", K_LBIT, 0, 1); clk();
    advance_to_tick(0, 9);
    push_exp("per0_20b", K_PER, 0, 20); push_exp("lock_recover", K_LBIT, 0, 1); clk();
    set_next(0, 22);
    advance_to_tick(0, 10);
    push_exp("lock_bad1", K_LBIT, 0, 1); clk();
    set_next(0, 24);
    advance_to_tick(0, 11);
    stop_ch(0);
    push_exp("per0_24", K_PER, 0, 24); push_exp("unlock0", K_LBIT, 0, 0); clk();

    // Ch1 at period 100: range error, never locks; timeout-set wins over clear
    start_ch(1, 100);
    advance_to_tick(1, 1); clk();
    advance_to_tick(1, 2);
    stop_ch(1);
    push_exp("err1_after_2nd", K_ERR, 1, 1); push_exp("ch1_nolock", K_LBIT, 1, 0); clk();
    wait_cycles(64);
    drive(); ERR_CLR = 1'b1;
    push_exp("err1_cleared", K_ERR, 1, 0); clk();
    drive();
    push_exp("err1_set_wins_tmo", K_ERR, 1, 1); clk();
    ERR_CLR = 1'b0;

    // Ch1 short period 5: out-of-range tick sets error even with a same-cycle clear
    drive(); ERR_CLR = 1'b1; push_exp("err1_clr2", K_ERR, 1, 0); clk(); ERR_CLR = 1'b0;
    start_ch(1, 5);
    advance_to_tick(1, 1); clk();
    advance_to_tick(1, 2);
    stop_ch(1);
    ERR_CLR = 1'b1;
    push_exp("err1_set_wins_tick", K_ERR, 1, 1); push_exp("per1_5", K_PER, 1, 5); clk();
    ERR_CLR = 1'b0;

    // Ch2 at period 30: lock, timeout keeps lock, relock, second failure unlocks
    start_ch(2, 30);
    advance_to_tick(2, 7);
    stop_ch(2);
    push_exp("ch2_lock", K_LBIT, 2, 1); clk();
    wait_cycles(64);
    drive(); push_exp("err2_pre_tmo", K_ERR, 2, 0); clk();
    drive();
    push_exp("err2_tmo", K_ERR, 2, 1); push_exp("ch2_tmo_keeps", K_LBIT, 2, 1);
    push_exp("per2_unchanged", K_PER, 2, 30);
    clk();
    wait_cycles(10);
    start_ch(2, 30);
    advance_to_tick(2, 7);
    stop_ch(2);
    push_exp("ch2_relock", K_LBIT, 2, 1); push_exp("per2_30", K_PER, 2, 30); clk();
    wait_cycles(80);
    push_exp("ch2_after_tmo2", K_LBIT, 2, 1); check_all();
    start_ch(2, 30);
    advance_to_tick(2, 1);
    stop_ch(2);
    push_exp("ch2_restart_start_only", K_LBIT, 2, 1); clk();
    wait_cycles(64);
    drive(); push_exp("ch2_pre_fail", K_LBIT, 2, 1); clk();
    drive(); push_exp("ch2_restart_fail", K_LBIT, 2, 0); clk();

    // All channels locked, then power-down behaviour of LOCKED_ALL
    for (int n = 0; n < CH; n++) start_ch(n, 20);
    advance_to_tick(0, 7);
    push_exp("lvec_pre_all", K_LVEC, 0, 0); push_exp("lall_pre_all", K_LALL, 0, 0); check_all();
    push_exp("lvec_all", K_LVEC, 0, 4'hF); push_exp("lall_all", K_LALL, 0, 1); clk();
    drive(); PWRDWN = 4'b1000;
    push_exp("pd3_lvec", K_LVEC, 0, 4'b0111); push_exp("pd3_lall", K_LALL, 0, 1); clk();
    wait_cycles(25);
    push_exp("pd3_lall_hold", K_LALL, 0, 1); check_all();
    drive(); PWRDWN = 4'hF;
    push_exp("pdall_lvec", K_LVEC, 0, 0); push_exp("pdall_lall", K_LALL, 0, 0); clk();
    wait_cycles(5);

    // Relock all, asynchronous reset between edges, full sequence required after
    PWRDWN = '0;
    for (int n = 0; n < CH; n++) start_ch(n, 20);
    advance_to_tick(0, 7);
    push_exp("relock_all", K_LVEC, 0, 4'hF); clk();
    #2;
    RST = 1'b1;
    #1;
    push_exp("arst_lvec", K_LVEC, 0, 0); push_exp("arst_lall", K_LALL, 0, 0);
    push_exp("arst_per0", K_PER, 0, 0); push_exp("arst_per2", K_PER, 2, 0);
    for (int n = 0; n < CH; n++) push_exp("arst_err", K_ERR, n, 0);
    check_all();
    clk();
    RST = 1'b0;
    for (int n = 0; n < CH; n++) ntick[n] = 0;
    advance_to_tick(0, 1);
    push_exp("post_rst_start_per0", K_PER, 0, 0); clk();
    advance_to_tick(0, 6);
    push_exp("post_rst_no_early_lock", K_LVEC, 0, 0); clk();
    advance_to_tick(0, 7);
    push_exp("post_rst_lock", K_LVEC, 0, 4'hF); push_exp("post_rst_lall", K_LALL, 0, 1); clk();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no completion, required finish before 1000000 time units");
    $fatal(1);
  end

endmodule
